// File: rtl/dut_exec_pkg.sv
// dut_exec_pkg: shared constants for the command executor.
//   - command codes (WRITE/READ/FILL/ROWSUM)
//   - FSM state encoding (3-bit, legacy-compatible localparams)
//   - SRAM address width and address type
//   - accept_state(): maps an accepted command to its first FSM state
// Build option: DUT_EXEC_ROWSUM_EN enables the ROWSUM command and the
// SUM/SUM_CAP states; without it 0x04 decodes as an unknown command.
package dut_exec_pkg;

    localparam int ADDR_W = 16;
    typedef logic [ADDR_W-1:0] sram_addr_t;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_FILL   = 8'h03;
    localparam logic [7:0] CMD_ROWSUM = 8'h04;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD      = 3'd2;
    localparam logic [2:0] ST_RD_CAP  = 3'd3;
    localparam logic [2:0] ST_FILL    = 3'd4;
`ifdef DUT_EXEC_ROWSUM_EN
    localparam logic [2:0] ST_SUM     = 3'd5;
    localparam logic [2:0] ST_SUM_CAP = 3'd6;
`endif
    localparam logic [2:0] ST_ERR     = 3'd7;

    // Every known command touches the SRAM, so SRAM_MODE=0 rejects them all.
    function automatic logic [2:0] accept_state(input logic [7:0] cmd,
                                                input logic       sram_mode);
        logic [2:0] st;
        case (cmd)
            CMD_WRITE:  st = ST_WR;
            CMD_READ:   st = ST_RD;
            CMD_FILL:   st = ST_FILL;
`ifdef DUT_EXEC_ROWSUM_EN
            CMD_ROWSUM: st = ST_SUM;
`endif
            default:    st = ST_ERR;
        endcase
        if (!sram_mode) st = ST_ERR;
        return st;
    endfunction

endpackage

// File: rtl/dut_cmd_exec.sv
// dut_cmd_exec: single-command SRAM executor driven by a UART controller.
// Ports:
//   CLK, RESET (async, active-high), CTR_RST (sync soft reset)
//   CTR_EN/CTR_CMD/DIN/ROW_ADDR/COL_ADDR/SUB_ADDR/SRAM_MODE : command input
//   CTR_IN_PROCESS : busy, high while the FSM is outside IDLE
//   DOUT : last read byte, TID_DATA : row sum, ERR : last command rejected
//   SRAM_CS/WE/ADDR/WDATA/RDATA : synchronous SRAM port (read data valid one
//     cycle after a CS=1, WE=0 cycle)
//   DBG_STATE : current FSM state for observation
// Handshake: a command is taken only when CTR_EN=1 in IDLE; while busy the
// strobe is dropped (no queue, no error).
// Build option: DUT_EXEC_ROWSUM_EN enables ROWSUM; otherwise TID_DATA is 0.
import dut_exec_pkg::*;

module dut_cmd_exec (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CTR_RST,
    input  logic             CTR_EN,
    input  logic [7:0]       CTR_CMD,
    input  logic [7:0]       DIN,
    input  logic [7:0]       ROW_ADDR,
    input  logic [3:0]       COL_ADDR,
    input  logic [3:0]       SUB_ADDR,
    input  logic             SRAM_MODE,
    output logic             CTR_IN_PROCESS,
    output logic [7:0]       DOUT,
    output logic [31:0]      TID_DATA,
    output logic             ERR,
    output logic             SRAM_CS,
    output logic             SRAM_WE,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [7:0]       SRAM_WDATA,
    input  logic [7:0]       SRAM_RDATA,
    output logic [2:0]       DBG_STATE
);

    logic [2:0] state;
    logic [7:0] idx;
    logic [2:0] accept_st;

    assign accept_st      = accept_state(CTR_CMD, SRAM_MODE);
    assign CTR_IN_PROCESS = (state != ST_IDLE);
    assign DBG_STATE      = state;

    // SRAM controls are registered together with the state so that each
    // access state drives a clean, glitch-free port for exactly its cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            idx        <= '0;
            DOUT       <= '0;
            ERR        <= 1'b0;
            SRAM_CS    <= 1'b0;
            SRAM_WE    <= 1'b0;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= '0;
        end else if (CTR_RST) begin
            state      <= ST_IDLE;
            idx        <= '0;
            DOUT       <= '0;
            ERR        <= 1'b0;
            SRAM_CS    <= 1'b0;
            SRAM_WE    <= 1'b0;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CTR_EN) begin
                        state      <= accept_st;
                        idx        <= '0;
                        ERR        <= 1'b0;
                        SRAM_WDATA <= DIN;
                        SRAM_ADDR  <= {ROW_ADDR, COL_ADDR, SUB_ADDR};
                        SRAM_CS    <= (accept_st != ST_ERR);
                        SRAM_WE    <= (accept_st == ST_WR) || (accept_st == ST_FILL);
                        // Row sweeps start at column/sub 0 regardless of the
                        // column and sub address supplied with the command.
                        if (accept_st == ST_FILL) SRAM_ADDR <= {ROW_ADDR, 8'h00};
`ifdef DUT_EXEC_ROWSUM_EN
                        if (accept_st == ST_SUM)  SRAM_ADDR <= {ROW_ADDR, 8'h00};
`endif
                    end
                end
                ST_WR: begin
                    state   <= ST_IDLE;
                    SRAM_CS <= 1'b0;
                    SRAM_WE <= 1'b0;
                end
                ST_RD: begin
                    state   <= ST_RD_CAP;
                    SRAM_CS <= 1'b0;
                end
                ST_RD_CAP: begin
                    state <= ST_IDLE;
                    DOUT  <= SRAM_RDATA;
                end
                ST_FILL: begin
                    if (idx == 8'hFF) begin
                        state   <= ST_IDLE;
                        SRAM_CS <= 1'b0;
                        SRAM_WE <= 1'b0;
                    end else begin
                        idx            <= idx + 8'd1;
                        SRAM_ADDR[7:0] <= idx + 8'd1;
                    end
                end
`ifdef DUT_EXEC_ROWSUM_EN
                ST_SUM: begin
                    if (idx == 8'hFF) begin
                        state   <= ST_SUM_CAP;
                        SRAM_CS <= 1'b0;
                    end else begin
                        idx            <= idx + 8'd1;
                        SRAM_ADDR[7:0] <= idx + 8'd1;
                    end
                end
                ST_SUM_CAP: begin
                    state <= ST_IDLE;
                end
`endif
                ST_ERR: begin
                    state <= ST_IDLE;
                    ERR   <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    SRAM_CS <= 1'b0;
                    SRAM_WE <= 1'b0;
                end
            endcase
        end
    end

`ifdef DUT_EXEC_ROWSUM_EN
    logic [31:0] tid_acc;

    // Read data lags the address by one cycle: in SUM with idx=k the bus
    // carries byte k-1 (nothing yet when k=0), and SUM_CAP carries byte 255.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tid_acc <= '0;
        end else if (CTR_RST) begin
            tid_acc <= '0;
        end else if (state == ST_IDLE && CTR_EN && accept_st == ST_SUM) begin
            tid_acc <= '0;
        end else if ((state == ST_SUM && idx != 8'd0) || state == ST_SUM_CAP) begin
            tid_acc <= tid_acc + {24'd0, SRAM_RDATA};
        end
    end

    assign TID_DATA = tid_acc;
`else
    assign TID_DATA = 32'd0;
`endif

endmodule

// File: tb/tb_dut_cmd_exec.sv
// tb_dut_cmd_exec: self-checking bench for dut_cmd_exec.
// A behavioural SRAM answers the DUT port; a command-level reference model
// (ref_mem image, expected DOUT/TID/ERR, busy length, expected write queue)
// predicts results from the command rules. Honors DUT_EXEC_ROWSUM_EN.
module tb_dut_cmd_exec;

`ifdef DUT_EXEC_ROWSUM_EN
    localparam bit ROWSUM_ON = 1'b1;
`else
    localparam bit ROWSUM_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst, ctr_rst, ctr_en, sram_mode;
    logic [7:0]  ctr_cmd, din, row_addr, dout, sram_wdata, sram_rdata;
    logic [3:0]  col_addr, sub_addr;
    logic        busy, err, sram_cs, sram_we;
    logic [15:0] sram_addr;
    logic [31:0] tid_data;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    dut_cmd_exec u_dut (
        .CLK(clk), .RESET(rst), .CTR_RST(ctr_rst), .CTR_EN(ctr_en),
        .CTR_CMD(ctr_cmd), .DIN(din), .ROW_ADDR(row_addr), .COL_ADDR(col_addr),
        .SUB_ADDR(sub_addr), .SRAM_MODE(sram_mode), .CTR_IN_PROCESS(busy),
        .DOUT(dout), .TID_DATA(tid_data), .ERR(err), .SRAM_CS(sram_cs),
        .SRAM_WE(sram_we), .SRAM_ADDR(sram_addr), .SRAM_WDATA(sram_wdata),
        .SRAM_RDATA(sram_rdata), .DBG_STATE(dbg_state)
    );

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- SRAM model ----------------
    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    logic [7:0] mem [65536];
    bit         written [65536];

    always @(posedge clk) begin
        if (sram_cs && sram_we) begin
            mem[sram_addr]     <= sram_wdata;
            written[sram_addr] <= 1'b1;
        end
        if (sram_cs && !sram_we)
            sram_rdata <= written[sram_addr] ? mem[sram_addr] : init_byte(sram_addr);
    end

    function automatic logic [7:0] sram_peek(input logic [15:0] a);
        return written[a] ? mem[a] : init_byte(a);
    endfunction

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q[$];          // {addr, data} of each expected write
    int          cs_count = 0;

    always @(negedge clk) begin
        logic [23:0] e;
        if (sram_cs === 1'b1) begin
            cs_count++;
            if (sram_we === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", sram_addr, sram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({sram_addr, sram_wdata} !== e) begin
                        n_bad++;
                        $display("FAIL wr_match: got addr=%h data=%h, required addr=%h data=%h",
                                 sram_addr, sram_wdata, e[23:8], e[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [65536];
    logic [7:0]  exp_dout = 8'h00;
    logic [31:0] exp_tid  = 32'd0;
    logic        exp_err  = 1'b0;

    task automatic model_cmd(input logic [7:0] cmd, input logic [7:0] d, input logic [7:0] row,
                             input logic [3:0] col, input logic [3:0] sub, input logic mode,
                             output int exp_busy, output int exp_cs);
        logic [15:0] a;
        bit          known;
        a = {row, col, sub};
        known = (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h03) || (cmd == 8'h04 && ROWSUM_ON);
        exp_busy = 1;
        exp_cs   = 0;
        if (!known || !mode) begin
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        case (cmd)
            8'h01: begin
                ref_mem[a] = d;
                exp_q.push_back({a, d});
                exp_cs = 1;
            end
            8'h02: begin
                exp_dout = ref_mem[a];
                exp_busy = 2;
                exp_cs   = 1;
            end
            8'h03: begin
                for (int i = 0; i < 256; i++) begin
                    ref_mem[{row, 8'(i)}] = d;
                    exp_q.push_back({row, 8'(i), d});
                end
                exp_busy = 256;
                exp_cs   = 256;
            end
            default: begin
                exp_tid = 32'd0;
                for (int i = 0; i < 256; i++) exp_tid += 32'(ref_mem[{row, 8'(i)}]);
                exp_busy = 257;
                exp_cs   = 256;
            end
        endcase
    endtask

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_cmd(input logic [7:0] cmd, input logic [7:0] d, input logic [7:0] row,
                             input logic [3:0] col, input logic [3:0] sub, input logic mode);
        ctr_cmd = cmd; din = d; row_addr = row; col_addr = col; sub_addr = sub;
        sram_mode = mode; ctr_en = 1'b1;
        @(negedge clk);
        ctr_en = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 2000) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; ctr_rst = 1'b0; ctr_en = 1'b0; ctr_cmd = '0; din = '0;
        row_addr = '0; col_addr = '0; sub_addr = '0; sram_mode = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, err, sram_cs, sram_we} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got busy/err/cs/we=%b, required 0000", {busy, err, sram_cs, sram_we});
        end
        n_total++;
        if (dout !== 8'h00 || tid_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data: got dout=%h tid=%h, required 00/0", dout, tid_data);
        end
        n_total++;
        if (sram_addr !== 16'h0000 || sram_wdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_port: got addr=%h wdata=%h, required 0000/00", sram_addr, sram_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int eb, ec, cyc, cs0;
        logic [7:0] old_dout;
        cs0 = cs_count;
        model_cmd(8'h01, 8'hA5, 8'h12, 4'h3, 4'h4, 1'b1, eb, ec);
        start_cmd(8'h01, 8'hA5, 8'h12, 4'h3, 4'h4, 1'b1);
        n_total++;
        if ({busy, sram_cs, sram_we} !== 3'b111 || sram_addr !== 16'h1234) begin
            n_bad++;
            $display("FAIL write_cycle: got busy/cs/we=%b addr=%h, required 111/1234", {busy, sram_cs, sram_we}, sram_addr);
        end
        wait_idle(cyc);
        n_total++;
        if (cyc !== eb || cs_count - cs0 !== ec) begin
            n_bad++;
            $display("FAIL write_busy: got busy=%0d cs=%0d, required %0d/%0d", cyc, cs_count - cs0, eb, ec);
        end

        old_dout = exp_dout;
        model_cmd(8'h02, 8'h00, 8'h12, 4'h3, 4'h4, 1'b1, eb, ec);
        start_cmd(8'h02, 8'h00, 8'h12, 4'h3, 4'h4, 1'b1);
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1 || dout !== old_dout) begin
            n_bad++;
            $display("FAIL read_cap_cycle: got busy=%b dout=%h, required 1/%h", busy, dout, old_dout);
        end
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || dout !== 8'hA5 || exp_dout !== 8'hA5) begin
            n_bad++;
            $display("FAIL read_done: got busy=%b dout=%h, required 0/a5", busy, dout);
        end
    endtask

    task automatic test_fill_rowsum();
        int eb, ec, cyc, cs0;
        cs0 = cs_count;
        model_cmd(8'h03, 8'h01, 8'h07, 4'h0, 4'h0, 1'b1, eb, ec);
        start_cmd(8'h03, 8'h01, 8'h07, 4'h9, 4'h2, 1'b1);
        wait_idle(cyc);
        n_total++;
        if (cyc !== 256 || cs_count - cs0 !== 256 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL fill_len: got busy=%0d cs=%0d left=%0d, required 256/256/0", cyc, cs_count - cs0, exp_q.size());
        end
        cs0 = cs_count;
        model_cmd(8'h04, 8'h00, 8'h07, 4'h0, 4'h0, 1'b1, eb, ec);
        start_cmd(8'h04, 8'h00, 8'h07, 4'h0, 4'h0, 1'b1);
        wait_idle(cyc);
        n_total++;
        if (cyc !== eb || cs_count - cs0 !== ec) begin
            n_bad++;
            $display("FAIL rowsum_len: got busy=%0d cs=%0d, required %0d/%0d", cyc, cs_count - cs0, eb, ec);
        end
        n_total++;
        if (tid_data !== exp_tid || err !== exp_err) begin
            n_bad++;
            $display("FAIL rowsum_val: got tid=%0d err=%b, required %0d/%b", tid_data, err, exp_tid, exp_err);
        end
    endtask

    task automatic test_error();
        int eb, ec, cyc, cs0;
        cs0 = cs_count;
        model_cmd(8'h55, 8'h00, 8'h00, 4'h0, 4'h0, 1'b1, eb, ec);
        start_cmd(8'h55, 8'h00, 8'h00, 4'h0, 4'h0, 1'b1);
        wait_idle(cyc);
        n_total++;
        if (err !== 1'b1 || cyc !== 1 || cs_count != cs0) begin
            n_bad++;
            $display("FAIL unknown_cmd: got err=%b busy=%0d cs=%0d, required 1/1/0", err, cyc, cs_count - cs0);
        end
        n_total++;
        if (dout !== exp_dout || tid_data !== exp_tid) begin
            n_bad++;
            $display("FAIL unknown_hold: got dout=%h tid=%0d, required %h/%0d", dout, tid_data, exp_dout, exp_tid);
        end
        model_cmd(8'h01, 8'h3E, 8'h30, 4'h1, 4'h1, 1'b1, eb, ec);
        start_cmd(8'h01, 8'h3E, 8'h30, 4'h1, 4'h1, 1'b1);
        wait_idle(cyc);
        n_total++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b, required 0", err);
        end
    endtask

    task automatic test_ctr_rst_fill();
        int bad_cells, cs0;
        for (int i = 0; i < 100; i++) begin
            ref_mem[{8'h07, 8'(i)}] = 8'h3C;
            exp_q.push_back({8'h07, 8'(i), 8'h3C});
        end
        start_cmd(8'h03, 8'h3C, 8'h07, 4'h0, 4'h0, 1'b1);
        repeat (99) @(negedge clk);
        n_total++;
        if (sram_addr !== 16'h0763) begin
            n_bad++;
            $display("FAIL fill_idx99: got addr=%h, required 0763", sram_addr);
        end
        ctr_rst = 1'b1;
        @(negedge clk);
        ctr_rst = 1'b0;
        exp_dout = 8'h00; exp_tid = 32'd0; exp_err = 1'b0;
        n_total++;
        if ({busy, sram_cs, sram_we, err} !== 4'b0000 || sram_addr !== 16'h0000 || dout !== 8'h00 || tid_data !== 32'd0) begin
            n_bad++;
            $display("FAIL soft_reset: got busy/cs/we/err=%b addr=%h dout=%h tid=%0d, required 0000/0000/00/0",
                     {busy, sram_cs, sram_we, err}, sram_addr, dout, tid_data);
        end
        repeat (3) @(negedge clk);
        bad_cells = 0;
        for (int i = 0; i < 256; i++)
            if (sram_peek({8'h07, 8'(i)}) !== ref_mem[{8'h07, 8'(i)}]) bad_cells++;
        n_total++;
        if (bad_cells != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL abort_image: got %0d wrong cells, %0d writes missing, required 0/0", bad_cells, exp_q.size());
        end
        // soft reset must win over a simultaneous strobe
        cs0 = cs_count;
        ctr_cmd = 8'h01; din = 8'h99; row_addr = 8'h31; col_addr = 4'h0; sub_addr = 4'h0;
        sram_mode = 1'b1; ctr_rst = 1'b1; ctr_en = 1'b1;
        @(negedge clk);
        ctr_rst = 1'b0; ctr_en = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || cs_count != cs0) begin
            n_bad++;
            $display("FAIL rst_priority: got busy=%b cs=%0d, required 0/0", busy, cs_count - cs0);
        end
    endtask

    task automatic test_busy_ignore();
        int eb, ec, cyc, cs0;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        model_cmd(8'h03, d, 8'h20, 4'h0, 4'h0, 1'b1, eb, ec);
        start_cmd(8'h03, d, 8'h20, 4'h0, 4'h0, 1'b1);
        repeat (50) @(negedge clk);
        ctr_cmd = 8'h01; din = 8'hEE; row_addr = 8'h30; col_addr = 4'h0; sub_addr = 4'h0; ctr_en = 1'b1;
        @(negedge clk);
        ctr_en = 1'b0;
        wait_idle(cyc);
        n_total++;
        if (51 + cyc !== 256 || err !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL busy_ignore: got busy=%0d err=%b left=%0d, required 256/0/0", 51 + cyc, err, exp_q.size());
        end
        cs0 = cs_count;
        model_cmd(8'h02, 8'h00, 8'h12, 4'h3, 4'h4, 1'b0, eb, ec);
        start_cmd(8'h02, 8'h00, 8'h12, 4'h3, 4'h4, 1'b0);
        wait_idle(cyc);
        n_total++;
        if (err !== 1'b1 || dout !== exp_dout || cs_count != cs0 || cyc !== 1) begin
            n_bad++;
            $display("FAIL mode_off_read: got err=%b dout=%h cs=%0d busy=%0d, required 1/%h/0/1",
                     err, dout, cs_count - cs0, cyc, exp_dout);
        end
    endtask

    task automatic test_back_to_back();
        int eb, ec, cyc;
        logic [7:0] d [4];
        for (int k = 0; k < 4; k++) begin
            d[k] = 8'($urandom_range(0, 255));
            model_cmd(8'h01, d[k], 8'h50, 4'(k), 4'(k + 1), 1'b1, eb, ec);
            start_cmd(8'h01, d[k], 8'h50, 4'(k), 4'(k + 1), 1'b1);
            wait_idle(cyc);
        end
        for (int k = 3; k >= 0; k--) begin
            model_cmd(8'h02, 8'h00, 8'h50, 4'(k), 4'(k + 1), 1'b1, eb, ec);
            start_cmd(8'h02, 8'h00, 8'h50, 4'(k), 4'(k + 1), 1'b1);
            wait_idle(cyc);
            n_total++;
            if (dout !== d[k] || cyc !== 2) begin
                n_bad++;
                $display("FAIL b2b_read%0d: got dout=%h busy=%0d, required %h/2", k, dout, cyc, d[k]);
            end
        end
    endtask

    task automatic test_random();
        int eb, ec, cyc, cs0, r;
        logic [7:0] cmd, d, row;
        logic [3:0] col, sub;
        logic       mode;
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: cmd = 8'h01;
                3, 4, 5: cmd = 8'h02;
                6:       cmd = 8'h03;
                7:       cmd = 8'h04;
                default: cmd = 8'($urandom_range(5, 255));
            endcase
            d    = 8'($urandom_range(0, 255));
            row  = 8'($urandom_range(8'h40, 8'h43));
            col  = 4'($urandom_range(0, 15));
            sub  = 4'($urandom_range(0, 15));
            mode = ($urandom_range(0, 7) != 0);
            cs0  = cs_count;
            model_cmd(cmd, d, row, col, sub, mode, eb, ec);
            start_cmd(cmd, d, row, col, sub, mode);
            wait_idle(cyc);
            n_total++;
            if (cyc !== eb || cs_count - cs0 !== ec || exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL rand%0d_timing: cmd=%h mode=%b got busy=%0d cs=%0d left=%0d, required %0d/%0d/0",
                         n, cmd, mode, cyc, cs_count - cs0, exp_q.size(), eb, ec);
            end
            n_total++;
            if (dout !== exp_dout || tid_data !== exp_tid || err !== exp_err) begin
                n_bad++;
                $display("FAIL rand%0d_result: cmd=%h got dout=%h tid=%0d err=%b, required %h/%0d/%b",
                         n, cmd, dout, tid_data, err, exp_dout, exp_tid, exp_err);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
        test_reset();
        test_write_read();
        test_fill_rowsum();
        test_error();
        test_ctr_rst_fill();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
